// File: rtl/tile_control_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tile_control_unit: sequences A/B block reads, PU accumulation and C writes
// for one output tile. Optional macro TILE_CU_GRANT_TIMEOUT_EN adds a grant timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tile_control_unit #(
  parameter int K              = 2,
  parameter int INDEX_WIDTH    = 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MU_WIDTH       = 8,
`ifdef TILE_CU_GRANT_TIMEOUT_EN
  parameter int TIMEOUT        = 64,
`endif
  localparam int EL_W = ((K * K) > 1) ? $clog2(K * K) : 1
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Indexes_Ready,
  input  logic [INDEX_WIDTH-1:0]    i_Row_Index,
  input  logic [INDEX_WIDTH-1:0]    i_Column_Index,
  input  logic [MU_WIDTH-1:0]       i_mu,
  input  logic [INDEX_WIDTH-1:0]    i_N,
  input  logic [MEM_ADDR_WIDTH-1:0] i_A_Base,
  input  logic [MEM_ADDR_WIDTH-1:0] i_B_Base,
  input  logic [MEM_ADDR_WIDTH-1:0] i_C_Base,
  output logic                      o_Indexes_Received,
  output logic                      o_Result_Ready,
  output logic                      o_Grant_Request,
  input  logic                      i_Grant,
  output logic [EL_W-1:0]           o_RF_Address,
  output logic                      o_RF_Write_Enable,
  output logic                      o_RF_Read_Enable,
  output logic                      o_AorB,
  output logic                      o_PU_Start,
  output logic                      o_PU_Clear,
  input  logic                      i_Partial_Output_Ready,
  output logic                      o_Memory_Read_Enable,
  output logic                      o_Memory_Write_Enable,
  output logic [MEM_ADDR_WIDTH-1:0] o_Memory_Address
`ifdef TILE_CU_GRANT_TIMEOUT_EN
  ,
  output logic                      o_Timeout
`endif
);

  localparam int                        KK     = K * K;
  localparam logic [EL_W-1:0]           E_LAST = EL_W'(KK - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] KK_M   = MEM_ADDR_WIDTH'(KK);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_RD  = 3'd1,
    RD_A    = 3'd2,
    RD_B    = 3'd3,
    PU_WAIT = 3'd4,
    REQ_WR  = 3'd5,
    WR      = 3'd6
  } state_t;

  state_t                    state, next_state;
  logic [INDEX_WIDTH-1:0]    row_q, col_q, n_q;
  logic [MU_WIDTH-1:0]       mu_q, x_q;
  logic [EL_W-1:0]           e_q;
  logic                      ack_q, start_q, clear_q, done_q;
  logic                      accept, burst_last, more_blocks, grant_ok, hold_off;
  logic [MEM_ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;

`ifdef TILE_CU_GRANT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_pulse;

  // The request is withdrawn for the single cycle the timeout pulse is high.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else if (!((state == REQ_RD) || (state == REQ_WR)) || to_pulse || i_Grant) begin
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
      to_cnt   <= '0;
      to_pulse <= 1'b1;
    end else begin
      to_cnt   <= to_cnt + TO_W'(1);
    end
  end

  assign o_Timeout = to_pulse;
  assign hold_off  = to_pulse;
`else
  assign hold_off  = 1'b0;
`endif

  assign burst_last  = (e_q == E_LAST);
  assign more_blocks = (({1'b0, x_q} + (MU_WIDTH + 1)'(1)) < {1'b0, mu_q});
  assign grant_ok    = i_Grant && !hold_off;

  assign a_addr = i_A_Base + ((MEM_ADDR_WIDTH'(row_q) * MEM_ADDR_WIDTH'(mu_q) + MEM_ADDR_WIDTH'(x_q)) * KK_M) + MEM_ADDR_WIDTH'(e_q);
  assign b_addr = i_B_Base + ((MEM_ADDR_WIDTH'(x_q) * MEM_ADDR_WIDTH'(n_q) + MEM_ADDR_WIDTH'(col_q)) * KK_M) + MEM_ADDR_WIDTH'(e_q);
  assign c_addr = i_C_Base + ((MEM_ADDR_WIDTH'(row_q) * MEM_ADDR_WIDTH'(n_q) + MEM_ADDR_WIDTH'(col_q)) * KK_M) + MEM_ADDR_WIDTH'(e_q);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state            = state;
    accept                = 1'b0;
    o_Grant_Request       = 1'b0;
    o_Memory_Read_Enable  = 1'b0;
    o_Memory_Write_Enable = 1'b0;
    o_RF_Write_Enable     = 1'b0;
    o_RF_Read_Enable      = 1'b0;
    o_AorB                = 1'b0;
    o_RF_Address          = '0;
    o_Memory_Address      = '0;
    case (state)
      IDLE: begin
        if (i_Indexes_Ready) begin
          accept     = 1'b1;
          next_state = (i_mu == '0) ? REQ_WR : REQ_RD;
        end
      end
      REQ_RD: begin
        o_Grant_Request = !hold_off;
        if (grant_ok) next_state = RD_A;
      end
      RD_A: begin
        o_Grant_Request      = 1'b1;
        o_Memory_Read_Enable = 1'b1;
        o_RF_Write_Enable    = 1'b1;
        o_RF_Address         = e_q;
        o_Memory_Address     = a_addr;
        if (burst_last) next_state = RD_B;
      end
      RD_B: begin
        o_Grant_Request      = 1'b1;
        o_Memory_Read_Enable = 1'b1;
        o_RF_Write_Enable    = 1'b1;
        o_AorB               = 1'b1;
        o_RF_Address         = e_q;
        o_Memory_Address     = b_addr;
        if (burst_last) next_state = PU_WAIT;
      end
      PU_WAIT: begin
        if (i_Partial_Output_Ready) next_state = more_blocks ? REQ_RD : REQ_WR;
      end
      REQ_WR: begin
        o_Grant_Request = !hold_off;
        if (grant_ok) next_state = WR;
      end
      WR: begin
        o_Grant_Request       = 1'b1;
        o_Memory_Write_Enable = 1'b1;
        o_RF_Read_Enable      = 1'b1;
        o_RF_Address          = e_q;
        o_Memory_Address      = c_addr;
        if (burst_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A zero-length inner loop still clears the PU so an all-zero C block is written.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      row_q   <= '0;
      col_q   <= '0;
      n_q     <= '0;
      mu_q    <= '0;
      x_q     <= '0;
      e_q     <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q   <= accept;
      start_q <= (state == RD_B) && burst_last;
      clear_q <= ((state == RD_B) && burst_last && (x_q == '0)) || (accept && (i_mu == '0));
      done_q  <= (state == WR) && burst_last;
      if (accept) begin
        row_q <= i_Row_Index;
        col_q <= i_Column_Index;
        n_q   <= i_N;
        mu_q  <= i_mu;
        x_q   <= '0;
      end else if ((state == PU_WAIT) && i_Partial_Output_Ready && more_blocks) begin
        x_q   <= x_q + MU_WIDTH'(1);
      end
      if (next_state != state)
        e_q <= '0;
      else if ((state == RD_A) || (state == RD_B) || (state == WR))
        e_q <= e_q + EL_W'(1);
    end
  end

  assign o_Indexes_Received = ack_q;
  assign o_PU_Start         = start_q;
  assign o_PU_Clear         = clear_q;
  assign o_Result_Ready     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_control_unit.sv
`default_nettype none
// Directed self-checking bench for tile_control_unit using a K=2 and a K=4 instance.
module tb_tile_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready2 = 1'b0, ready4 = 1'b0, grant = 1'b0, pr = 1'b0;
  logic [7:0] row = '0, col = '0, n = '0, mu = '0;
  logic [9:0] abase = '0, bbase = '0, cbase = '0;

  logic ack2, done2, greq2, rfwe2, rfre2, aorb2, start2, clr2, mrd2, mwr2;
  logic [1:0] rfa2;
  logic [9:0] maddr2;
  logic ack4, done4, greq4, rfwe4, rfre4, aorb4, start4, clr4, mrd4, mwr4;
  logic [3:0] rfa4;
  logic [9:0] maddr4;
`ifdef TILE_CU_GRANT_TIMEOUT_EN
  logic to2, to4;
`endif

  // {ack, req, mem_rd, mem_wr, rf_we, rf_re, aorb, pu_start, pu_clear, result_ready}
  logic [9:0] ctl2, ctl4;
  assign ctl2 = {ack2, greq2, mrd2, mwr2, rfwe2, rfre2, aorb2, start2, clr2, done2};
  assign ctl4 = {ack4, greq4, mrd4, mwr4, rfwe4, rfre4, aorb4, start4, clr4, done4};

  localparam logic [9:0] V_IDLE   = 10'b0000000000;
  localparam logic [9:0] V_ACK    = 10'b1100000000;
  localparam logic [9:0] V_ACK0   = 10'b1100000010;
  localparam logic [9:0] V_REQ    = 10'b0100000000;
  localparam logic [9:0] V_RDA    = 10'b0110100000;
  localparam logic [9:0] V_RDB    = 10'b0110101000;
  localparam logic [9:0] V_PUS    = 10'b0000000110;
  localparam logic [9:0] V_PUS_NC = 10'b0000000100;
  localparam logic [9:0] V_WR     = 10'b0101010000;
  localparam logic [9:0] V_DONE   = 10'b0000000001;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tile_control_unit #(.K(2)) u_k2 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Indexes_Ready(ready2),
    .i_Row_Index(row), .i_Column_Index(col), .i_mu(mu), .i_N(n),
    .i_A_Base(abase), .i_B_Base(bbase), .i_C_Base(cbase),
    .o_Indexes_Received(ack2), .o_Result_Ready(done2),
    .o_Grant_Request(greq2), .i_Grant(grant),
    .o_RF_Address(rfa2), .o_RF_Write_Enable(rfwe2), .o_RF_Read_Enable(rfre2), .o_AorB(aorb2),
    .o_PU_Start(start2), .o_PU_Clear(clr2), .i_Partial_Output_Ready(pr),
    .o_Memory_Read_Enable(mrd2), .o_Memory_Write_Enable(mwr2), .o_Memory_Address(maddr2)
`ifdef TILE_CU_GRANT_TIMEOUT_EN
    , .o_Timeout(to2)
`endif
  );

  tile_control_unit #(
    .K(4)
`ifdef TILE_CU_GRANT_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) u_k4 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Indexes_Ready(ready4),
    .i_Row_Index(row), .i_Column_Index(col), .i_mu(mu), .i_N(n),
    .i_A_Base(abase), .i_B_Base(bbase), .i_C_Base(cbase),
    .o_Indexes_Received(ack4), .o_Result_Ready(done4),
    .o_Grant_Request(greq4), .i_Grant(grant),
    .o_RF_Address(rfa4), .o_RF_Write_Enable(rfwe4), .o_RF_Read_Enable(rfre4), .o_AorB(aorb4),
    .o_PU_Start(start4), .o_PU_Clear(clr4), .i_Partial_Output_Ready(pr),
    .o_Memory_Read_Enable(mrd4), .o_Memory_Write_Enable(mwr4), .o_Memory_Address(maddr4)
`ifdef TILE_CU_GRANT_TIMEOUT_EN
    , .o_Timeout(to4)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ctl2, maddr2, rfa2} !== 22'd0) begin failures++; $display("FAIL reset_k2 got=%h exp=0", {ctl2, maddr2, rfa2}); end
    checks++;
    if ({ctl4, maddr4, rfa4} !== 24'd0) begin failures++; $display("FAIL reset_k4 got=%h exp=0", {ctl4, maddr4, rfa4}); end
`ifdef TILE_CU_GRANT_TIMEOUT_EN
    checks++;
    if ({to2, to4} !== 2'b00) begin failures++; $display("FAIL reset_timeout got=%b exp=00", {to2, to4}); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [9:0] exp_c, exp_a;
    row = 8'd0; col = 8'd0; mu = 8'd1; n = 8'd1;
    abase = 10'd0; bbase = 10'd100; cbase = 10'd200; grant = 1'b1; pr = 1'b0;
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    checks++;
    if (ctl2 !== V_ACK) begin failures++; $display("FAIL basic_ack ctl=%b exp=%b", ctl2, V_ACK); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_c = (k < 4) ? V_RDA : V_RDB;
      exp_a = (k < 4) ? 10'(k) : 10'(100 + k - 4);
      checks++;
      if (ctl2 !== exp_c || maddr2 !== exp_a || rfa2 !== 2'(k % 4)) begin
        failures++;
        $display("FAIL basic_read k=%0d ctl=%b/%b addr=%0d/%0d rf=%0d/%0d", k, ctl2, exp_c, maddr2, exp_a, rfa2, k % 4);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_PUS) begin failures++; $display("FAIL basic_pu_start ctl=%b exp=%b", ctl2, V_PUS); end
    pr = 1'b1;
    @(negedge clk);
    pr = 1'b0;
    checks++;
    if (ctl2 !== V_REQ) begin failures++; $display("FAIL basic_req_wr ctl=%b exp=%b", ctl2, V_REQ); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ctl2 !== V_WR || maddr2 !== 10'(200 + k) || rfa2 !== 2'(k)) begin
        failures++;
        $display("FAIL basic_write k=%0d ctl=%b/%b addr=%0d/%0d rf=%0d/%0d", k, ctl2, V_WR, maddr2, 200 + k, rfa2, k);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_DONE) begin failures++; $display("FAIL basic_done ctl=%b exp=%b", ctl2, V_DONE); end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_IDLE) begin failures++; $display("FAIL basic_idle ctl=%b exp=%b", ctl2, V_IDLE); end
  endtask

  task automatic test_mu_zero();
    row = 8'd1; col = 8'd1; mu = 8'd0; n = 8'd2;
    abase = 10'd0; bbase = 10'd100; cbase = 10'd300; grant = 1'b1;
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    checks++;
    if (ctl2 !== V_ACK0) begin failures++; $display("FAIL mu0_ack_clear ctl=%b exp=%b", ctl2, V_ACK0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ctl2 !== V_WR || maddr2 !== 10'(312 + k)) begin
        failures++;
        $display("FAIL mu0_write k=%0d ctl=%b/%b addr=%0d/%0d", k, ctl2, V_WR, maddr2, 312 + k);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_DONE) begin failures++; $display("FAIL mu0_done ctl=%b exp=%b", ctl2, V_DONE); end
  endtask

  task automatic test_k4_multi();
    logic [9:0] exp_c, exp_a;
    row = 8'd1; col = 8'd0; mu = 8'd3; n = 8'd3;
    abase = 10'd0; bbase = 10'd400; cbase = 10'd800; grant = 1'b1; pr = 1'b0;
    ready4 = 1'b1;
    @(negedge clk);
    ready4 = 1'b0;
    checks++;
    if (ctl4 !== V_ACK) begin failures++; $display("FAIL k4_ack ctl=%b exp=%b", ctl4, V_ACK); end
    for (int x = 0; x < 3; x++) begin
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        exp_c = (k < 16) ? V_RDA : V_RDB;
        exp_a = (k < 16) ? 10'((3 + x) * 16 + k) : 10'(400 + x * 48 + k - 16);
        checks++;
        if (ctl4 !== exp_c || maddr4 !== exp_a || rfa4 !== 4'(k % 16)) begin
          failures++;
          $display("FAIL k4_read x=%0d k=%0d ctl=%b/%b addr=%0d/%0d rf=%0d/%0d", x, k, ctl4, exp_c, maddr4, exp_a, rfa4, k % 16);
        end
      end
      @(negedge clk);
      exp_c = (x == 0) ? V_PUS : V_PUS_NC;
      checks++;
      if (ctl4 !== exp_c) begin failures++; $display("FAIL k4_pu x=%0d ctl=%b exp=%b", x, ctl4, exp_c); end
      pr = 1'b1;
      @(negedge clk);
      pr = 1'b0;
      checks++;
      if (ctl4 !== V_REQ) begin failures++; $display("FAIL k4_req x=%0d ctl=%b exp=%b", x, ctl4, V_REQ); end
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (ctl4 !== V_WR || maddr4 !== 10'(848 + k)) begin
        failures++;
        $display("FAIL k4_write k=%0d ctl=%b/%b addr=%0d/%0d", k, ctl4, V_WR, maddr4, 848 + k);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl4 !== V_DONE) begin failures++; $display("FAIL k4_done ctl=%b exp=%b", ctl4, V_DONE); end
  endtask

  task automatic test_grant_delay();
    logic [9:0] exp_c, exp_a;
    row = 8'd0; col = 8'd0; mu = 8'd1; n = 8'd1;
    abase = 10'd0; bbase = 10'd100; cbase = 10'd200; grant = 1'b0; pr = 1'b0;
    ready2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl2 !== V_ACK) begin failures++; $display("FAIL gd_ack ctl=%b exp=%b", ctl2, V_ACK); end
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (ctl2 !== V_REQ) begin failures++; $display("FAIL gd_wait k=%0d ctl=%b exp=%b", k, ctl2, V_REQ); end
    end
    grant = 1'b1;
    pr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_c = (k < 4) ? V_RDA : V_RDB;
      exp_a = (k < 4) ? 10'(k) : 10'(100 + k - 4);
      checks++;
      if (ctl2 !== exp_c || maddr2 !== exp_a) begin
        failures++;
        $display("FAIL gd_read k=%0d ctl=%b/%b addr=%0d/%0d", k, ctl2, exp_c, maddr2, exp_a);
      end
      if (k == 3) pr = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_PUS) begin failures++; $display("FAIL gd_pu ctl=%b exp=%b", ctl2, V_PUS); end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_IDLE) begin failures++; $display("FAIL gd_pu_hold ctl=%b exp=%b", ctl2, V_IDLE); end
    pr = 1'b1;
    @(negedge clk);
    pr = 1'b0;
    checks++;
    if (ctl2 !== V_REQ) begin failures++; $display("FAIL gd_req_wr ctl=%b exp=%b", ctl2, V_REQ); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ctl2 !== V_WR || maddr2 !== 10'(200 + k)) begin
        failures++;
        $display("FAIL gd_write k=%0d ctl=%b/%b addr=%0d/%0d", k, ctl2, V_WR, maddr2, 200 + k);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_DONE) begin failures++; $display("FAIL gd_done ctl=%b exp=%b", ctl2, V_DONE); end
    @(negedge clk);
    checks++;
    if (ctl2 !== V_ACK) begin failures++; $display("FAIL gd_reaccept ctl=%b exp=%b", ctl2, V_ACK); end
    ready2 = 1'b0;
    grant = 1'b0;
  endtask

  task automatic test_reset_midburst();
    test_reset();
    row = 8'd0; col = 8'd0; mu = 8'd1; n = 8'd1;
    abase = 10'd0; bbase = 10'd100; cbase = 10'd200; grant = 1'b1; pr = 1'b0;
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (ctl2 !== V_RDB || maddr2 !== 10'd101 || rfa2 !== 2'd1) begin
      failures++;
      $display("FAIL mid_rdb1 ctl=%b/%b addr=%0d/101 rf=%0d/1", ctl2, V_RDB, maddr2, rfa2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl2, maddr2, rfa2} !== 22'd0) begin failures++; $display("FAIL mid_async_reset got=%h exp=0", {ctl2, maddr2, rfa2}); end
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
  endtask

`ifdef TILE_CU_GRANT_TIMEOUT_EN
  task automatic test_timeout();
    logic exp_to;
    test_reset();
    row = 8'd0; col = 8'd0; mu = 8'd1; n = 8'd1; grant = 1'b0; pr = 1'b0;
    ready4 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready4 = 1'b0;
      exp_to = (c == 8) || (c == 17);
      checks++;
      if (to4 !== exp_to || greq4 !== !exp_to) begin
        failures++;
        $display("FAIL timeout c=%0d to=%b/%b req=%b/%b", c, to4, exp_to, greq4, !exp_to);
      end
    end
    test_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_mu_zero();
    test_k4_multi();
    test_grant_delay();
    test_reset_midburst();
`ifdef TILE_CU_GRANT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
